icache_dm: RTL and testbench



---
 rtl/icache_dm_if.sv | 33 +++
 rtl/icache_dm.sv | 99 +++++++++
 tb/tb_icache_dm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-side signals of the direct-mapped instruction cache
//   fetch side : imemREN, imemaddr, inv -> cache; ihit, imemload <- cache
//   memory side: iREN, iaddr <- cache; iwait, iload -> cache
//   ICACHE_STATS_EN adds hit_count and miss_count driven by the cache
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        inv;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif
  modport slave (
    input  imemREN, imemaddr, inv, iwait, iload,
`ifdef ICACHE_STATS_EN
    output hit_count, miss_count,
`endif
    output ihit, imemload, iREN, iaddr
  );
  modport master (
    output imemREN, imemaddr, inv, iwait, iload,
`ifdef ICACHE_STATS_EN
    input  hit_count, miss_count,
`endif
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: blocking direct-mapped instruction cache with multi-word line fill and whole-cache invalidate
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : icache_dm_if.slave (fetch port, memory instruction channel, optional counters)
//   ICACHE_STATS_EN : builds hit_count / miss_count
module icache_dm #(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input logic        CLK,
  input logic        nRST,
  icache_dm_if.slave bus
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int CW = OB > 0 ? OB : 1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t          r_state, w_next;
  logic [SETS-1:0] r_valid;
  logic [TB-1:0]   r_tag [SETS];
  logic [31:0]     r_data [SETS][WORDS];
  logic [TB-1:0]   r_mtag;
  logic [IB-1:0]   r_midx;
  logic [CW-1:0]   r_cnt;
  logic [TB-1:0]   w_tag;
  logic [IB-1:0]   w_idx;
  logic [CW-1:0]   w_off;
  logic [31:0]     w_faddr;
  logic            w_hit, w_ihit, w_last, w_start, w_take, w_unused;
  assign w_tag    = bus.imemaddr[31:2+OB+IB];
  assign w_idx    = bus.imemaddr[2+OB+IB-1:2+OB];
  assign w_unused = &{1'b0, bus.imemaddr[1:0]};
  if (OB > 0) begin : g_off
    assign w_off   = bus.imemaddr[2+OB-1:2];
    assign w_faddr = {r_mtag, r_midx, r_cnt, 2'b00};
  end else begin : g_noff
    assign w_off   = '0;
    assign w_faddr = {r_mtag, r_midx, 2'b00};
  end
  assign w_hit   = r_valid[w_idx] && r_tag[w_idx] == w_tag && r_state == IDLE;
  assign w_ihit  = bus.imemREN && w_hit && !bus.inv;
  assign w_last  = r_cnt == CW'(WORDS - 1);
  assign w_start = r_state == IDLE && bus.imemREN && !w_hit && !bus.inv;
  // an invalidate discards the fill, so no word is written in that cycle
  assign w_take  = r_state == FILL && !bus.iwait && !bus.inv;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_start ? FILL : IDLE)
                             : (bus.inv || (w_take && w_last) ? IDLE : FILL);
  end
  assign bus.ihit     = w_ihit;
  assign bus.imemload = r_data[w_idx][w_off];
  assign bus.iREN     = r_state == FILL;
  assign bus.iaddr    = r_state == FILL ? w_faddr : '0;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_mtag  <= '0;
      r_midx  <= '0;
      r_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_tag[s] <= '0;
        for (int w = 0; w < WORDS; w++) r_data[s][w] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (bus.inv) r_valid <= '0;
      if (w_start) begin
        r_mtag <= w_tag;
        r_midx <= w_idx;
        r_cnt  <= '0;
      end
      if (w_take) begin
        r_data[r_midx][r_cnt] <= bus.iload;
        r_cnt <= r_cnt + 1'b1;
        // the line becomes visible only once its final word is in
        if (w_last) begin
          r_tag[r_midx]   <= r_mtag;
          r_valid[r_midx] <= 1'b1;
        end
      end
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] r_hits, r_misses;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_ihit) r_hits <= r_hits + 1'b1;
      if (w_start) r_misses <= r_misses + 1'b1;
    end
  end
  assign bus.hit_count  = r_hits;
  assign bus.miss_count = r_misses;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for icache_dm (SETS=16, WORDS=2) with a stalling memory model
module tb_icache_dm;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;
  icache_dm_if bus ();
  icache_dm #(.SETS(16), .WORDS(2)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  int n_tests = 0, n_fail = 0, stall_n = 0, exp_hits = 0, exp_miss = 0;
  logic [31:0] exp_q [$];
  logic [31:0] seen_q [$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h0BAD_F00D;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    bus.iwait = bus.iREN && stall_n > 0;
    if (bus.iwait) stall_n--;
    bus.iload = mem_word(bus.iaddr);
    #1;
  endtask
  task automatic fetch(input logic [31:0] a, input int lat, input string tag);
    int n = 0;
    exp_q.push_back(mem_word({a[31:2], 2'b00}));
    seen_q.delete();
    if (lat > 0) exp_miss++;
    exp_hits++;
    bus.imemREN = 1'b1;
    bus.imemaddr = a;
    #1;
    while (!bus.ihit && n < 40) begin
      if (bus.iREN) seen_q.push_back(bus.iaddr);
      tick();
      n++;
    end
    chk({tag, " ihit"}, 32'(bus.ihit), 32'd1);
    chk({tag, " latency"}, n, lat);
    chk({tag, " data"}, bus.imemload, exp_q.pop_front());
    chk({tag, " iREN at hit"}, 32'(bus.iREN), 32'd0);
    tick();
    bus.imemREN = 1'b0;
    #1;
  endtask
  task automatic chk_seen(input string tag, input logic [31:0] a0, input int waits);
    logic [31:0] exp [$];
    for (int i = 0; i <= waits; i++) exp.push_back(a0);
    exp.push_back(a0 + 32'd4);
    chk({tag, " req count"}, seen_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++)
      chk($sformatf("%s iaddr[%0d]", tag, i), seen_q[i], exp[i]);
  endtask
  task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
    chk({tag, " hit_count"}, bus.hit_count, exp_hits);
    chk({tag, " miss_count"}, bus.miss_count, exp_miss);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask
  initial begin
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.inv = 1'b0;
    bus.iwait = 1'b0;
    bus.iload = '0;
    tick();
    tick();
    nRST = 1'b1;
    #1;
    chk("reset ihit", 32'(bus.ihit), 32'd0);
    chk("reset iREN", 32'(bus.iREN), 32'd0);
    chk("reset iaddr", bus.iaddr, 32'd0);
    chk("reset imemload", bus.imemload, 32'd0);
    chk_stats("reset");
    fetch(32'h40, 3, "cold 0x40");
    chk_seen("cold 0x40", 32'h40, 0);
    fetch(32'h44, 0, "hit 0x44");
    fetch(32'h42, 0, "hit 0x42");
    chk_stats("after hits");
    fetch(32'h840, 3, "conflict 0x840");
    chk_seen("conflict 0x840", 32'h840, 0);
    fetch(32'h40, 3, "refetch 0x40");
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h40;
    bus.inv = 1'b1;
    #1;
    chk("inv masks ihit", 32'(bus.ihit), 32'd0);
    tick();
    bus.imemREN = 1'b0;
    bus.inv = 1'b0;
    #1;
    chk("inv no fill", 32'(bus.iREN), 32'd0);
    stall_n = 3;
    fetch(32'h40, 6, "stalled 0x40");
    chk_seen("stalled 0x40", 32'h40, 3);
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h80;
    #1;
    chk("abort detect ihit", 32'(bus.ihit), 32'd0);
    exp_miss++;
    tick();
    chk("abort fill0 iREN", 32'(bus.iREN), 32'd1);
    chk("abort fill0 iaddr", bus.iaddr, 32'h80);
    tick();
    bus.imemREN = 1'b0;
    bus.inv = 1'b1;
    #1;
    chk("abort fill1 iaddr", bus.iaddr, 32'h84);
    tick();
    bus.inv = 1'b0;
    #1;
    chk("abort iREN drop", 32'(bus.iREN), 32'd0);
    chk("abort iaddr drop", bus.iaddr, 32'd0);
    fetch(32'h40, 3, "post-inv 0x40");
    fetch(32'h80, 3, "post-inv 0x80");
    fetch(32'h84, 0, "hit 0x84");
    chk_stats("final");
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h100;
    #1;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.imemREN = 1'b0;
    bus.imemaddr = 32'h40;
    #1;
    exp_hits = 0;
    exp_miss = 0;
    chk("mid-fill reset iREN", 32'(bus.iREN), 32'd0);
    chk("mid-fill reset imemload", bus.imemload, 32'd0);
    chk_stats("mid-fill reset");
    fetch(32'h40, 3, "after reset 0x40");
    chk_stats("after reset");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
